// File: rtl/anim_rect_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : anim_rect_generator_if
// Description : Pixel/control/status bundle for the animated rectangle.
//               master = video/game side, slave = rectangle generator.
//               Ports (master view):
//                 x, y, enb           current pixel and draw enable
//                 frame_tick, move_en once-per-frame motion request
//                 load, load_x/y      run-time position load
//                 red/green/blue      registered pixel colour (returned)
//                 xpos, ypos          current position (returned)
//                 hit_x, hit_y        bounce pulses (returned)
// Revision    : 1.0 - initial release
// ============================================================================
interface anim_rect_generator_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic        enb;
    logic        frame_tick;
    logic        move_en;
    logic        load;
    logic [10:0] load_x;
    logic [9:0]  load_y;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [10:0] xpos;
    logic [9:0]  ypos;
    logic        hit_x;
    logic        hit_y;

    modport master (
        output x, y, enb, frame_tick, move_en, load, load_x, load_y,
        input  red, green, blue, xpos, ypos, hit_x, hit_y
    );

    modport slave (
        input  x, y, enb, frame_tick, move_en, load, load_x, load_y,
        output red, green, blue, xpos, ypos, hit_x, hit_y
    );
endinterface
`default_nettype wire

// File: rtl/anim_rect_generator.sv
`default_nettype none
// ============================================================================
// Module      : anim_rect_generator
// Description : Solid rectangle of fixed size/colour whose position lives in
//               registers. Position can be loaded, or advanced by STEP per
//               axis on each frame_tick (when move_en) with bounce off the
//               screen edges. Colour output is registered (1-cycle latency).
// Ports       : clk        pixel clock
//               reset      synchronous, active-high
//               bus        anim_rect_generator_if.slave (pixel in, colour,
//                          position and bounce pulses out)
// Options     : RECT_BORDER_EN - draw only a BORDER-thick outline instead of
//               a solid fill.
// Revision    : 1.0 - initial release
// ============================================================================
module anim_rect_generator #(
    parameter int         XPOS0  = 100,
    parameter int         YPOS0  = 100,
    parameter int         WIDTH  = 100,
    parameter int         HEIGHT = 100,
    parameter logic [3:0] RVAL   = 4'd0,
    parameter logic [3:0] GVAL   = 4'd0,
    parameter logic [3:0] BVAL   = 4'd0,
    parameter int         XMAX   = 640,
    parameter int         YMAX   = 480,
    parameter int         STEP   = 1,
    parameter int         BORDER = 2
) (
    input wire                    clk,
    input wire                    reset,
    anim_rect_generator_if.slave  bus
);

`ifdef RECT_BORDER_EN
    localparam bit c_border_en = 1'b1;
`else
    localparam bit c_border_en = 1'b0;
`endif

    // All position arithmetic is 12-bit so sums near 2047 never wrap.
    localparam logic [11:0] c_width      = 12'(WIDTH);
    localparam logic [11:0] c_height     = 12'(HEIGHT);
    localparam logic [11:0] c_step       = 12'(STEP);
    localparam logic [11:0] c_xmax       = 12'(XMAX);
    localparam logic [11:0] c_ymax       = 12'(YMAX);
    localparam logic [11:0] c_xstop      = 12'(XMAX - WIDTH);
    localparam logic [11:0] c_ystop      = 12'(YMAX - HEIGHT);
    localparam logic [11:0] c_border     = 12'(BORDER);
    localparam logic [11:0] c_w_inner    = 12'(WIDTH - BORDER);
    localparam logic [11:0] c_h_inner    = 12'(HEIGHT - BORDER);

    logic [10:0] xpos_q,  xpos_d;
    logic [9:0]  ypos_q,  ypos_d;
    logic        dx_q,    dx_d;
    logic        dy_q,    dy_d;
    logic        hit_x_q, hit_x_d;
    logic        hit_y_q, hit_y_d;
    logic [3:0]  red_q,   red_d;
    logic [3:0]  green_q, green_d;
    logic [3:0]  blue_q,  blue_d;

    logic [11:0] w_xpos_ext, w_ypos_ext, w_x_ext, w_y_ext;
    logic [11:0] w_x_move, w_y_move;
    logic        w_x_bounce, w_y_bounce;
    logic        w_in_x, w_in_y, w_ring, w_lit;

    assign w_xpos_ext = {1'b0, xpos_q};
    assign w_ypos_ext = {2'b00, ypos_q};
    assign w_x_ext    = {1'b0, bus.x};
    assign w_y_ext    = {2'b00, bus.y};

    // Candidate position for a motion tick; bounce clamps to the screen edge.
    always_comb begin
        w_x_move   = w_xpos_ext;
        w_x_bounce = 1'b0;
        if (dx_q) begin
            if (w_xpos_ext + c_width + c_step <= c_xmax) begin
                w_x_move = w_xpos_ext + c_step;
            end else begin
                w_x_move   = c_xstop;
                w_x_bounce = 1'b1;
            end
        end else begin
            if (w_xpos_ext >= c_step) begin
                w_x_move = w_xpos_ext - c_step;
            end else begin
                w_x_move   = 12'd0;
                w_x_bounce = 1'b1;
            end
        end
    end

    always_comb begin
        w_y_move   = w_ypos_ext;
        w_y_bounce = 1'b0;
        if (dy_q) begin
            if (w_ypos_ext + c_height + c_step <= c_ymax) begin
                w_y_move = w_ypos_ext + c_step;
            end else begin
                w_y_move   = c_ystop;
                w_y_bounce = 1'b1;
            end
        end else begin
            if (w_ypos_ext >= c_step) begin
                w_y_move = w_ypos_ext - c_step;
            end else begin
                w_y_move   = 12'd0;
                w_y_bounce = 1'b1;
            end
        end
    end

    // Pixel test against the position held before this edge; edges exclusive.
    assign w_in_x = (w_xpos_ext < w_x_ext) && (w_x_ext < w_xpos_ext + c_width);
    assign w_in_y = (w_ypos_ext < w_y_ext) && (w_y_ext < w_ypos_ext + c_height);
    assign w_ring = (w_x_ext <= w_xpos_ext + c_border) ||
                    (w_x_ext >= w_xpos_ext + c_w_inner) ||
                    (w_y_ext <= w_ypos_ext + c_border) ||
                    (w_y_ext >= w_ypos_ext + c_h_inner);
    assign w_lit  = bus.enb && w_in_x && w_in_y && (w_ring || !c_border_en);

    always_comb begin
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hit_x_d = 1'b0;
        hit_y_d = 1'b0;
        red_d   = w_lit ? RVAL : 4'd0;
        green_d = w_lit ? GVAL : 4'd0;
        blue_d  = w_lit ? BVAL : 4'd0;
        if (bus.load) begin
            // Load overrides any coincident tick and leaves direction alone.
            xpos_d = bus.load_x;
            ypos_d = bus.load_y;
        end else if (bus.frame_tick && bus.move_en) begin
            xpos_d  = w_x_move[10:0];
            ypos_d  = w_y_move[9:0];
            dx_d    = dx_q ^ w_x_bounce;
            dy_d    = dy_q ^ w_y_bounce;
            hit_x_d = w_x_bounce;
            hit_y_d = w_y_bounce;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xpos_q  <= 11'(XPOS0);
            ypos_q  <= 10'(YPOS0);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            hit_x_q <= 1'b0;
            hit_y_q <= 1'b0;
            red_q   <= 4'd0;
            green_q <= 4'd0;
            blue_q  <= 4'd0;
        end else begin
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            hit_x_q <= hit_x_d;
            hit_y_q <= hit_y_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign bus.red   = red_q;
    assign bus.green = green_q;
    assign bus.blue  = blue_q;
    assign bus.xpos  = xpos_q;
    assign bus.ypos  = ypos_q;
    assign bus.hit_x = hit_x_q;
    assign bus.hit_y = hit_y_q;

endmodule
`default_nettype wire

// File: doc/anim_rect_generator.md
# anim_rect_generator

Parametrised, registered successor to the static wall/rectangle generator in the VGA path. Draws one solid rectangle of fixed size and colour, but its position is held in registers. The position can be loaded at run time or advanced once per frame with automatic bounce off the screen edges. It sits between the VGA timing counter (x, y) and the colour mixer. It also exports its position and bounce pulses so game logic (Pong ball, Life cursor) can react.

## Interface
- XPOS0, 100: reset x position (left edge, exclusive)
- YPOS0, 100: reset y position (top edge, exclusive)
- WIDTH, 100: rectangle width in pixels
- HEIGHT, 100: rectangle height in pixels
- RVAL / GVAL / BVAL, 0: 4-bit colour when lit
- XMAX, 640: visible screen width
- YMAX, 480: visible screen height
- STEP, 1: pixels moved per axis per frame_tick; 1..WIDTH
- BORDER, 2: outline thickness; used only under RECT_BORDER_EN

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- x  in  11  current pixel column
- y  in  10  current pixel row
- enb  in  1  video active / draw enable
- frame_tick  in  1  one-cycle pulse, once per frame (end of visible area)
- move_en  in  1  allow motion on frame_tick
- load  in  1  load position from load_x/load_y
- load_x  in  11  position to load
- load_y  in  10  position to load
- red / green / blue  out  4 each  registered pixel colour
- xpos  out  11  current x position
- ypos  out  10  current y position
- hit_x  out  1  one-cycle pulse when x direction reverses
- hit_y  out  1  one-cycle pulse when y direction reverses

## Operation
- State: xpos, ypos, dx (1 = +x), dy (1 = +y), colour regs, hit_x, hit_y.
- Reset: xpos=XPOS0, ypos=YPOS0, dx=1, dy=1, red/green/blue=0, hit_x=hit_y=0.
- Priority per cycle: reset > load > (frame_tick & move_en) > hold.
- load: xpos<=load_x, ypos<=load_y. dx/dy are unchanged and no hit pulse is raised.
- Move, x axis (y identical with YMAX/HEIGHT/dy/hit_y):
  - dx=1 and xpos+WIDTH+STEP <= XMAX: xpos += STEP.
  - dx=1 otherwise: xpos <= XMAX-WIDTH, dx <= 0, hit_x=1.
  - dx=0 and xpos >= STEP: xpos -= STEP.
  - dx=0 otherwise: xpos <= 0, dx <= 1, hit_x=1.
- Both axes may bounce in the same tick, giving a corner hit where hit_x and hit_y pulse together.
- hit_x and hit_y are 0 on every cycle where no bounce occurs.
- Pixel test: lit = enb & (xpos < x < xpos+WIDTH) & (ypos < y < ypos+HEIGHT). Edges are exclusive.
- All sums use 12-bit arithmetic so no wrap occurs at xpos near 2047.
- Colour outputs are RVAL/GVAL/BVAL when lit, else 0.

## Timing
- Pixel latency is 1 cycle: x/y/enb sampled at edge N produce the colour valid after edge N.
- The pixel test uses xpos/ypos as they were before edge N. A position update at edge N is seen from edge N+1.
- xpos/ypos/hit_* update on the edge that samples load or frame_tick, so they are visible the following cycle.
- A frame_tick in the same cycle as load is ignored (load wins).
- Asserting reset mid-frame returns the block to the reset state on the next edge. Colour is 0 in the cycle after reset.
- frame_tick while move_en=0 changes nothing.

## Configuration
- RECT_BORDER_EN defined: outline mode.
  - lit additionally requires x <= xpos+BORDER, or x >= xpos+WIDTH-BORDER, or the same test for y.
  - Interior pixels output 0.
- RECT_BORDER_EN undefined: solid fill as described above. BORDER has no effect.

## Test plan
- Reset with defaults; sweep x=101, y=101, enb=1 → colour=(RVAL,GVAL,BVAL) one cycle later. x=100 or x=200 → 0. enb=0 → 0.
- STEP=4, WIDTH=100, load x=536: first tick → xpos=540, no hit. Second tick → xpos=540, dx=0, hit_x=1 for one cycle. Third tick → xpos=536.
- dx=0 after load x=2 with STEP=4: tick → xpos=0, dx=1, hit_x=1. Next tick → xpos=4.
- Corner: load (540,380) with defaults, move right/down at STEP=1: tick → xpos=540, ypos=380, hit_x=hit_y=1 in the same cycle.
- load and frame_tick in the same cycle with load_x=50 → xpos=50 and no motion. Reset asserted mid-move → xpos=100, ypos=100, dx=dy=1, outputs 0.
- RECT_BORDER_EN, BORDER=2, rect at (100,100): pixel (101,150) lit. Pixel (150,150) → 0. Pixel (198,150) lit.
